// File: rtl/clk_freq_mon.sv
// Clock-frequency monitor: counts synchronized rising edges of the returned pad
// clock over a fixed int_clk window and grades each window against bounds.
module clk_freq_mon #(
    parameter int WIN_CYC = 256,
    parameter int EXP_LO  = 31,
    parameter int EXP_HI  = 33,
    parameter int LOCK_N  = 2,
    parameter int CNT_W   = 8
) (
    input  logic             int_clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mon_clk_i,
    input  logic             clr_fault,
    output logic [CNT_W-1:0] meas_cnt,
    output logic             meas_valid,
    output logic             in_range,
    output logic             locked,
    output logic             fault
);

    localparam int WCW = (WIN_CYC > 1) ? $clog2(WIN_CYC) : 1;
    localparam int LKW = $clog2(LOCK_N + 1);

    localparam logic [WCW-1:0]   WIN_LAST  = WCW'(WIN_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] BOUND_LO  = CNT_W'(EXP_LO);
    localparam logic [CNT_W-1:0] BOUND_HI  = CNT_W'(EXP_HI);
    localparam logic [LKW-1:0]   LOCK_FULL = LKW'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        MEASURE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [2:0]       mon_pipe;
    logic             edge_det;
    logic [1:0]       settle_cnt;
    logic [WCW-1:0]   win_cnt;
    logic [CNT_W-1:0] edge_cnt;
    logic [CNT_W-1:0] cnt_final;
    logic [LKW-1:0]   lock_cnt;
    logic             win_close;
    logic             win_ok;

    // [0],[1] form the synchronizer; [2] is the previous synchronized level.
    always_ff @(posedge int_clk) begin
        if (rst) mon_pipe <= '0;
        else     mon_pipe <= {mon_pipe[1:0], mon_clk_i};
    end

    assign edge_det = mon_pipe[1] & ~mon_pipe[2];

    always_ff @(posedge int_clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            unique case (state)
                IDLE:    state_nxt = SETTLE;
                SETTLE:  if (settle_cnt == 2'd3) state_nxt = MEASURE;
                MEASURE: state_nxt = MEASURE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // The edge seen on the closing cycle is folded into the result of that window.
    assign cnt_final = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign win_close = en && (state == MEASURE) && (win_cnt == WIN_LAST);
    assign win_ok    = (cnt_final >= BOUND_LO) && (cnt_final <= BOUND_HI);

    always_ff @(posedge int_clk) begin
        if (rst || !en) begin
            settle_cnt <= '0;
            win_cnt    <= '0;
            edge_cnt   <= '0;
        end else begin
            unique case (state)
                SETTLE: begin
                    settle_cnt <= settle_cnt + 2'd1;
                    win_cnt    <= '0;
                    edge_cnt   <= '0;
                end
                MEASURE: begin
                    settle_cnt <= '0;
                    if (win_cnt == WIN_LAST) begin
                        win_cnt  <= '0;
                        edge_cnt <= '0;
                    end else begin
                        win_cnt  <= win_cnt + WCW'(1);
                        edge_cnt <= cnt_final;
                    end
                end
                default: begin
                    settle_cnt <= '0;
                    win_cnt    <= '0;
                    edge_cnt   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge int_clk) begin
        if (rst) begin
            meas_cnt   <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            lock_cnt   <= '0;
            fault      <= 1'b0;
        end else begin
            meas_valid <= win_close;
            if (win_close) begin
                meas_cnt <= cnt_final;
                in_range <= win_ok;
                if (!win_ok)                     lock_cnt <= '0;
                else if (lock_cnt != LOCK_FULL)  lock_cnt <= lock_cnt + LKW'(1);
            end else if (!en) begin
                lock_cnt <= '0;
            end
            // A bad window outranks a coincident clear.
            if (win_close && !win_ok) fault <= 1'b1;
            else if (clr_fault)       fault <= 1'b0;
        end
    end

    assign locked = (lock_cnt == LOCK_FULL);

endmodule

// File: tb/tb_clk_freq_mon.sv
// Randomized bench for clk_freq_mon: a history-based model recounts rises over
// each expected window span; a CNT_W=7 copy covers counter saturation.
module tb_clk_freq_mon;
    localparam int WIN    = 256;
    localparam int LO     = 31;
    localparam int HI     = 33;
    localparam int LOCK_N = 2;
    localparam int MAXC   = 60000;

    logic int_clk = 1'b0;
    logic rst = 1'b1, en = 1'b0, mon_clk_i = 1'b0, clr_fault = 1'b0;
    logic [7:0] meas_cnt;
    logic       meas_valid, in_range, locked, fault;
    logic [6:0] s_meas_cnt;
    logic       s_meas_valid, s_in_range, s_locked, s_fault;

    always #5 int_clk = ~int_clk;

    clk_freq_mon #(.WIN_CYC(WIN), .EXP_LO(LO), .EXP_HI(HI), .LOCK_N(LOCK_N), .CNT_W(8)) u_dut (
        .int_clk(int_clk), .rst(rst), .en(en), .mon_clk_i(mon_clk_i), .clr_fault(clr_fault),
        .meas_cnt(meas_cnt), .meas_valid(meas_valid), .in_range(in_range),
        .locked(locked), .fault(fault));

    clk_freq_mon #(.WIN_CYC(WIN), .EXP_LO(LO), .EXP_HI(HI), .LOCK_N(LOCK_N), .CNT_W(7)) u_sat (
        .int_clk(int_clk), .rst(rst), .en(en), .mon_clk_i(mon_clk_i), .clr_fault(clr_fault),
        .meas_cnt(s_meas_cnt), .meas_valid(s_meas_valid), .in_range(s_in_range),
        .locked(s_locked), .fault(s_fault));

    int n_vec = 0, n_err = 0, cyc = 0;
    bit samp[MAXC];

    // reference model state
    bit act, x_vld, x_inr, x_fault;
    int e_cyc, streak, x_cnt, x_sat;

    // stimulus shape: 0 constant level, 1 divided clock, 2 random bits
    int mode = 0, half = 4, ph = 0;
    bit lvl = 1'b0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            if (n_err <= 25) $display("FAIL %s @cyc %0d: got %0d want %0d", tag, cyc, obs, exp);
        end
    endtask

    // rising edges of the sampled input that land in the window closing at p
    function automatic int rises(input int p);
        int r = 0;
        for (int m = p - WIN; m < p; m++)
            if (samp[m-1] && !samp[m-2]) r++;
        return r;
    endfunction

    task automatic model_edge();
        samp[cyc] = mon_clk_i;
        x_vld = 1'b0;
        if (rst) begin
            act = 0; streak = 0; x_cnt = 0; x_sat = 0; x_inr = 0; x_fault = 0;
        end else begin
            if (!en) begin
                act = 0; streak = 0;
            end else if (!act) begin
                act = 1; e_cyc = cyc;
            end else if ((cyc - e_cyc - 4) >= WIN && ((cyc - e_cyc - 4) % WIN) == 0) begin
                int r;
                r = rises(cyc);
                x_cnt  = (r > 255) ? 255 : r;
                x_sat  = (r > 127) ? 127 : r;
                x_inr  = (x_cnt >= LO) && (x_cnt <= HI);
                x_vld  = 1'b1;
                streak = x_inr ? streak + 1 : 0;
            end
            if (x_vld && !x_inr) x_fault = 1'b1;
            else if (clr_fault)  x_fault = 1'b0;
        end
    endtask

    task automatic step();
        case (mode)
            0:       mon_clk_i = lvl;
            1:       mon_clk_i = (((cyc + 1 + ph) / half) % 2) != 0;
            default: mon_clk_i = ($urandom & 1) != 0;
        endcase
        @(posedge int_clk);
        cyc++;
        model_edge();
        @(negedge int_clk);
        chk("valid",   meas_valid,   x_vld);
        chk("cnt",     meas_cnt,     x_cnt);
        chk("inrange", in_range,     x_inr);
        chk("locked",  locked,       streak >= LOCK_N);
        chk("fault",   fault,        x_fault);
        chk("s_valid", s_meas_valid, x_vld);
        chk("s_cnt",   s_meas_cnt,   x_sat);
        chk("s_fault", s_fault,      x_fault);
    endtask

    task automatic run_valid(input int n);
        int seen = 0;
        int budget = n * WIN + WIN + 20;
        while (seen < n && budget > 0) begin
            step();
            if (meas_valid) seen++;
            budget--;
        end
        if (seen < n) chk("valid_timeout", seen, n);
    endtask

    initial begin
        int raise_cyc;
        bit got;

        // reset state
        repeat (3) step();
        chk("rst_cnt", meas_cnt, 0);
        chk("rst_fault", fault, 0);

        // int_clk/8: 32 per window, lock on the second result
        rst = 1'b0; en = 1'b1; mode = 1; half = 4; ph = $urandom_range(7, 0);
        run_valid(2);
        chk("div8_cnt", meas_cnt, 32);
        chk("div8_lock", locked, 1);
        run_valid(1);

        // stuck low: zero count, fault, then a clean clear
        mode = 0; lvl = 1'b0;
        run_valid(2);
        chk("stuck_cnt", meas_cnt, 0);
        chk("stuck_fault", fault, 1);
        chk("stuck_lock", locked, 0);
        repeat (5) step();
        clr_fault = 1'b1; step(); clr_fault = 1'b0;
        step();
        chk("clr_fault", fault, 0);

        // relock at /8, then /4 drops lock and raises fault on one update
        mode = 1; half = 4; ph = $urandom_range(7, 0);
        run_valid(3);
        chk("relock", locked, 1);
        half = 2;
        run_valid(1);
        chk("div4_unlock", locked, 0);
        chk("div4_fault", fault, 1);
        run_valid(1);
        chk("div4_cnt", meas_cnt, 64);

        // clear coinciding with a bad close: set wins
        repeat (WIN - 1) step();
        clr_fault = 1'b1; step(); clr_fault = 1'b0;
        chk("clr_vs_set_vld", meas_valid, 1);
        chk("clr_vs_set", fault, 1);

        // drop enable mid-window, re-raise, measure re-arm latency
        repeat (99) step();
        en = 1'b0;
        repeat (10) step();
        en = 1'b1; half = 4; raise_cyc = cyc;
        got = 1'b0;
        for (int i = 0; i < 400 && !got; i++) begin
            step();
            if (meas_valid) got = 1'b1;
        end
        chk("rearm_seen", got, 1);
        chk("rearm_lat", cyc - raise_cyc, 261);

        // random segments with sporadic clears, enable toggles and resets
        for (int seg = 0; seg < 16; seg++) begin
            int len;
            mode = $urandom_range(2, 0);
            half = $urandom_range(12, 1);
            ph   = $urandom_range(23, 0);
            lvl  = ($urandom & 1) != 0;
            len  = $urandom_range(700, 100);
            for (int i = 0; i < len; i++) begin
                clr_fault = ($urandom_range(49, 0) == 0);
                if ($urandom_range(299, 0) == 0) en = ~en;
                rst = ($urandom_range(999, 0) == 0);
                step();
            end
        end
        clr_fault = 1'b0; rst = 1'b0; en = 1'b1;

        // int_clk/2 saturates the narrow counter
        mode = 1; half = 1; ph = 0;
        run_valid(3);
        chk("sat_cnt", s_meas_cnt, 127);
        chk("sat_fault", s_fault, 1);
        chk("wide_cnt", meas_cnt, 128);

        // reset mid-window clears everything on the next cycle
        repeat (100) step();
        rst = 1'b1; step();
        chk("rstmid_cnt", meas_cnt, 0);
        chk("rstmid_inr", in_range, 0);
        chk("rstmid_lock", locked, 0);
        chk("rstmid_fault", fault, 0);
        chk("rstmid_vld", meas_valid, 0);
        rst = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #(MAXC * 10 - 100);
        $display("FAIL watchdog: got cycle %0d want finish before %0d", cyc, MAXC);
        $fatal(1);
    end
endmodule
